rtc_core: RTL

- Free-running real-time clock counter that consumes the time-setting stage's {h,m,s} load word and load strobe.
- Counts seconds from the 1 kHz system tick and keeps HH:MM:SS in 24 h form, with derived 12 h/AM-PM and BCD views for the display stage.
- Sits directly downstream of the time-setting UI and upstream of the LCD line formatter.

---
 rtl/rtc_core.sv | 95 +++++++++
 1 files changed

// File: rtl/rtc_core.sv
// rtc_core: seconds counter from the 1 kHz tick, keeping 24 h HH:MM:SS
// with a range-checked {h,m,s} load and derived 12 h/AM-PM and BCD views.
module rtc_core #(
    parameter int TICKS_PER_SEC = 1000,
    parameter int PS_W          = 10
) (
    input  logic        clk_1kHz,
    input  logic        resetn,
    input  logic [20:0] i_load_data,
    input  logic        i_load_sig,
    input  logic        i_run,
    output logic [6:0]  o_hour,
    output logic [6:0]  o_min,
    output logic [6:0]  o_sec,
    output logic [20:0] o_time,
    output logic [6:0]  o_hour12,
    output logic        o_pm,
    output logic [23:0] o_bcd,
    output logic        o_sec_tick,
    output logic        o_day_tick,
    output logic        o_load_err
);
    logic [6:0]      h, m, s;
    logic [PS_W-1:0] ps;
    logic            load_q, sec_tick, day_tick, load_err;
    logic            load_edge, load_ok, term, inc, s_wrap, m_wrap, h_wrap;
    logic [6:0]      ld_h, ld_m, ld_s, h_nx, m_nx, s_nx;

    function automatic logic [7:0] bcd2(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    always_comb begin
        ld_h      = i_load_data[20:14];
        ld_m      = i_load_data[13:7];
        ld_s      = i_load_data[6:0];
        load_edge = i_load_sig & ~load_q;
        load_ok   = (ld_h <= 7'd23) && (ld_m <= 7'd59) && (ld_s <= 7'd59);
        term      = ps == PS_W'(TICKS_PER_SEC - 1);
        inc       = i_run & ~i_load_sig & term;
        s_wrap    = s == 7'd59;
        m_wrap    = m == 7'd59;
        h_wrap    = h == 7'd23;
        s_nx      = s_wrap ? 7'd0 : s + 7'd1;
        m_nx      = s_wrap ? (m_wrap ? 7'd0 : m + 7'd1) : m;
        h_nx      = (s_wrap && m_wrap) ? (h_wrap ? 7'd0 : h + 7'd1) : h;
    end

    // A held load level keeps ps at zero, so the first second after release is a full one.
    always_ff @(posedge clk_1kHz or negedge resetn) begin
        if (!resetn) begin
            h        <= '0;
            m        <= '0;
            s        <= '0;
            ps       <= '0;
            load_q   <= 1'b0;
            sec_tick <= 1'b0;
            day_tick <= 1'b0;
            load_err <= 1'b0;
        end else begin
            load_q   <= i_load_sig;
            sec_tick <= inc;
            day_tick <= inc & s_wrap & m_wrap & h_wrap;
            if (i_load_sig)
                ps <= '0;
            else if (i_run)
                ps <= term ? '0 : ps + PS_W'(1);
            if (load_edge) begin
                load_err <= ~load_ok;
                if (load_ok) begin
                    h <= ld_h;
                    m <= ld_m;
                    s <= ld_s;
                end
            end else if (inc) begin
                h <= h_nx;
                m <= m_nx;
                s <= s_nx;
            end
        end
    end

    always_comb begin
        o_hour     = h;
        o_min      = m;
        o_sec      = s;
        o_time     = {h, m, s};
        o_hour12   = (h == 7'd0) ? 7'd12 : (h > 7'd12 ? h - 7'd12 : h);
        o_pm       = h >= 7'd12;
        o_bcd      = {bcd2(h), bcd2(m), bcd2(s)};
        o_sec_tick = sec_tick;
        o_day_tick = day_tick;
        o_load_err = load_err;
    end
endmodule
